// File: rtl/decade_onehot_decoder.sv
// Receive-side checker for a one-hot decade counter: decodes the position bus,
// flags one-hot/step/carry faults, tracks lock and counts completed decades.
// Build option: define DECADE_SAT_EN to make the decade counter saturate instead of wrap.
module decade_onehot_decoder #(
  parameter int N        = 10,
  parameter int DEC_W    = 16,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [N-1:0]     q_in,
  input  logic             carry_in,
  input  logic             clr_err,
  output logic [3:0]       count_out,
  output logic             valid,
  output logic [DEC_W-1:0] decades,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_carry,
  output logic             locked
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(N - 1);
  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             prev_valid_q, prev_valid_d;
  logic [3:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic [DEC_W-1:0] decades_q, decades_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic             err_carry_q, err_carry_d;

  // Decode of the sampled bus
  logic [4:0]       ones;
  logic [3:0]       idx;
  logic             legal;
  logic [3:0]       next_prev;
  logic             seq_err;
  logic             carry_err;
  logic             clean;
  logic             wrap;
  logic [3:0]       run_inc;
  logic [DEC_W-1:0] decades_inc;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (q_in[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
  end

  // count_q doubles as the previous legal index used by the step check.
  assign legal     = (ones == 5'd1);
  assign next_prev = (count_q == LAST_IDX) ? 4'd0 : count_q + 4'd1;
  assign seq_err   = legal && prev_valid_q && (idx != count_q) && (idx != next_prev);
  assign carry_err = legal && (carry_in != q_in[N-1]);
  assign clean     = legal && !seq_err && !carry_err;
  assign wrap      = clean && prev_valid_q && (count_q == LAST_IDX) && (idx == 4'd0);
  assign run_inc   = run_q + 4'd1;

`ifdef DECADE_SAT_EN
  assign decades_inc = (decades_q == '1) ? decades_q : decades_q + DEC_W'(1);
`else
  assign decades_inc = decades_q + DEC_W'(1);
`endif

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    prev_valid_d = prev_valid_q;
    count_d      = count_q;
    valid_d      = valid_q;
    decades_d    = decades_q;
    // A clear and a new error in the same cycle leave the flag set.
    err_onehot_d = clr_err ? 1'b0 : err_onehot_q;
    err_seq_d    = clr_err ? 1'b0 : err_seq_q;
    err_carry_d  = clr_err ? 1'b0 : err_carry_q;

    if (sample_en) begin
      if (!legal) begin
        valid_d      = 1'b0;
        err_onehot_d = 1'b1;
        state_d      = ST_UNLOCKED;
        run_d        = '0;
      end else begin
        valid_d      = 1'b1;
        count_d      = idx;
        prev_valid_d = 1'b1;
        if (seq_err) begin
          err_seq_d = 1'b1;
        end
        if (carry_err) begin
          err_carry_d = 1'b1;
        end
        if (!clean) begin
          state_d = ST_UNLOCKED;
          run_d   = '0;
        end else begin
          if (wrap) begin
            decades_d = decades_inc;
          end
          if (state_q != ST_LOCKED) begin
            run_d   = run_inc;
            state_d = (run_inc >= LOCK_TGT) ? ST_LOCKED : ST_TRACK;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      run_q        <= '0;
      prev_valid_q <= 1'b0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      decades_q    <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_valid_q <= prev_valid_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      decades_q    <= decades_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_carry_q  <= err_carry_d;
    end
  end

  assign count_out  = count_q;
  assign valid      = valid_q;
  assign decades    = decades_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_carry  = err_carry_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_decade_onehot_decoder.sv
// Directed bench for decade_onehot_decoder: a behavioural model pushes expected
// outputs to a scoreboard per sample, popped and compared one clock later.
module tb_decade_onehot_decoder;

  localparam int N        = 10;
  localparam int DEC_W    = 2;
  localparam int LOCK_CNT = 3;
  localparam int DEC_MAX  = (1 << DEC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic [N-1:0]     q_in = '0;
  logic             carry_in = 1'b0;
  logic             clr_err = 1'b0;
  logic [3:0]       count_out;
  logic             valid;
  logic [DEC_W-1:0] decades;
  logic             err_onehot;
  logic             err_seq;
  logic             err_carry;
  logic             locked;

  decade_onehot_decoder #(.N(N), .DEC_W(DEC_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .q_in       (q_in),
    .carry_in   (carry_in),
    .clr_err    (clr_err),
    .count_out  (count_out),
    .valid      (valid),
    .decades    (decades),
    .err_onehot (err_onehot),
    .err_seq    (err_seq),
    .err_carry  (err_carry),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       count;
    logic             valid;
    logic [DEC_W-1:0] dec;
    logic             eo;
    logic             es;
    logic             ec;
    logic             locked;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state (state: 0 unlocked, 1 track, 2 locked)
  int m_count, m_dec, m_run, m_state;
  bit m_valid, m_eo, m_es, m_ec, m_pv;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = N'(1);
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_dec = 0; m_run = 0; m_state = 0;
    m_valid = 0; m_eo = 0; m_es = 0; m_ec = 0; m_pv = 0;
  endtask

  task automatic model_step(input logic [N-1:0] q, input logic c, input logic en, input logic clr);
    int  idx;
    bit  seqbad, cbad;
    if (clr) begin
      m_eo = 0; m_es = 0; m_ec = 0;
    end
    if (en) begin
      if ($countones(q) != 1) begin
        m_valid = 0; m_eo = 1; m_state = 0; m_run = 0;
      end else begin
        idx = 0;
        for (int i = 0; i < N; i++) if (q[i]) idx = i;
        seqbad  = m_pv && !(idx == m_count || idx == (m_count + 1) % N);
        cbad    = (c != q[N-1]);
        m_valid = 1;
        if (seqbad) m_es = 1;
        if (cbad) m_ec = 1;
        if (seqbad || cbad) begin
          m_state = 0; m_run = 0;
        end else begin
          if (m_pv && m_count == N - 1 && idx == 0) begin
`ifdef DECADE_SAT_EN
            m_dec = (m_dec == DEC_MAX) ? DEC_MAX : m_dec + 1;
`else
            m_dec = (m_dec + 1) % (DEC_MAX + 1);
`endif
          end
          if (m_state != 2) begin
            m_run++;
            m_state = (m_run >= LOCK_CNT) ? 2 : 1;
          end
        end
        m_count = idx;
        m_pv    = 1;
      end
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.count  = 4'(m_count);
    e.valid  = m_valid;
    e.dec    = DEC_W'(m_dec);
    e.eo     = m_eo;
    e.es     = m_es;
    e.ec     = m_ec;
    e.locked = (m_state == 2);
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, ".count"},  32'(count_out),  32'(e.count));
    check({tag, ".valid"},  32'(valid),      32'(e.valid));
    check({tag, ".dec"},    32'(decades),    32'(e.dec));
    check({tag, ".eo"},     32'(err_onehot), 32'(e.eo));
    check({tag, ".es"},     32'(err_seq),    32'(e.es));
    check({tag, ".ec"},     32'(err_carry),  32'(e.ec));
    check({tag, ".locked"}, 32'(locked),     32'(e.locked));
  endtask

  task automatic step(input logic [N-1:0] q, input logic c, input logic en, input logic clr,
                      input string tag);
    @(negedge clk);
    q_in = q; carry_in = c; sample_en = en; clr_err = clr;
    model_step(q, c, en, clr);
    push_model();
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  // Asynchronous reset: outputs are checked 1 time unit after rst rises, before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    sample_en = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    push_model();
    compare_out(tag);
    check({tag, ".const_locked"}, 32'(locked), 32'd0);
    check({tag, ".const_dec"},    32'(decades), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    push_model();
    compare_out("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean count 0..9,0 with matching carry
    for (int i = 0; i <= 10; i++) begin
      step(oh(i % 10), (i % 10) == 9, 1'b1, 1'b0, "clean_seq");
      if (i == 1) check("seq_unlocked_2nd", 32'(locked), 32'd0);
      if (i == 2) check("seq_locked_3rd", 32'(locked), 32'd1);
    end
    check("seq_decades", 32'(decades), 32'd1);
    check("seq_count_wrap", 32'(count_out), 32'd0);

    // One-hot violations
    step('0, 1'b0, 1'b1, 1'b0, "zero_hot");
    check("zero_hot_valid", 32'(valid), 32'd0);
    check("zero_hot_eo", 32'(err_onehot), 32'd1);
    step(10'b0000100100, 1'b0, 1'b1, 1'b0, "two_hot");
    check("two_hot_count_hold", 32'(count_out), 32'd0);
    check("two_hot_locked", 32'(locked), 32'd0);
    step('0, 1'b0, 1'b0, 1'b1, "clr_eo");
    check("clr_eo_flag", 32'(err_onehot), 32'd0);

    // Lock at index 3, then jump to 6
    for (int i = 1; i <= 3; i++) step(oh(i), 1'b0, 1'b1, 1'b0, "relock");
    check("relock_at3", 32'(locked), 32'd1);
    step(oh(6), 1'b0, 1'b1, 1'b0, "jump6");
    check("jump6_es", 32'(err_seq), 32'd1);
    check("jump6_count", 32'(count_out), 32'd6);
    check("jump6_locked", 32'(locked), 32'd0);
    step(oh(7), 1'b0, 1'b1, 1'b0, "after_jump");
    check("after_jump_track", 32'(locked), 32'd0);
    step(oh(8), 1'b0, 1'b1, 1'b0, "after_jump");
    step(oh(9), 1'b1, 1'b1, 1'b0, "after_jump");
    check("after_jump_relock", 32'(locked), 32'd1);
    step(oh(0), 1'b0, 1'b1, 1'b0, "after_jump");
    check("after_jump_dec", 32'(decades), 32'd2);

    // Carry faults
    for (int i = 1; i <= 8; i++) step(oh(i), 1'b0, 1'b1, 1'b0, "pre_carry");
    step(oh(9), 1'b0, 1'b1, 1'b0, "carry_missing");
    check("carry_missing_ec", 32'(err_carry), 32'd1);
    check("carry_missing_locked", 32'(locked), 32'd0);
    do_reset("rst_carry");
    step(oh(3), 1'b0, 1'b1, 1'b0, "pre_spur");
    step(oh(4), 1'b1, 1'b1, 1'b0, "carry_spurious");
    check("carry_spurious_ec", 32'(err_carry), 32'd1);
    check("carry_spurious_es", 32'(err_seq), 32'd0);

    // Held index, sample_en freeze, async reset
    do_reset("rst_hold");
    for (int i = 0; i < 4; i++) step(oh(5), 1'b0, 1'b1, 1'b0, "hold5");
    check("hold5_locked", 32'(locked), 32'd1);
    check("hold5_dec", 32'(decades), 32'd0);
    step('0, 1'b1, 1'b0, 1'b0, "frozen");
    check("frozen_count", 32'(count_out), 32'd5);
    check("frozen_valid", 32'(valid), 32'd1);
    do_reset("async_rst");

    // Five full wraps on a 2-bit decade counter
    step(oh(0), 1'b0, 1'b1, 1'b0, "wrap_start");
    for (int w = 0; w < 5; w++) begin
      for (int i = 1; i <= 10; i++) step(oh(i % 10), (i % 10) == 9, 1'b1, 1'b0, "wraps");
    end
`ifdef DECADE_SAT_EN
    check("wraps_dec", 32'(decades), 32'd3);
`else
    check("wraps_dec", 32'(decades), 32'd1);
`endif

    // Clear colliding with a new error
    step('0, 1'b0, 1'b1, 1'b0, "eo_set");
    step('0, 1'b0, 1'b1, 1'b1, "clr_vs_eo");
    check("clr_vs_eo_flag", 32'(err_onehot), 32'd1);
    step(oh(5), 1'b0, 1'b1, 1'b1, "clr_vs_es");
    check("clr_vs_es_flag", 32'(err_seq), 32'd1);
    check("clr_vs_es_eo", 32'(err_onehot), 32'd0);
    step('0, 1'b0, 1'b0, 1'b1, "clr_all");
    check("clr_all_es", 32'(err_seq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
